// File: rtl/demux_1x4_nbit_reg.sv
// ============================================================================
// demux_1x4_nbit_reg
// ----------------------------------------------------------------------------
// Registered 1-to-4 demultiplexer. One producer pushes N-bit words through a
// valid/ready handshake; each word lands in one of four single-entry holding
// registers (channels A/B/C/D), each with its own valid flag and consumer ack.
// The destination is either the explicit select S or an internal round-robin
// pointer (AUTO=1). It serves as the fan-out stage that feeds four consumers
// from one producer.
//
// Parameters:
//   n          data width of the input and of every channel (n >= 1)
//
// Ports:
//   CLK        system clock, all state changes on the rising edge
//   RST_N      synchronous active-low reset
//   X          input data word
//   X_VALID    producer presents a word on X
//   X_READY    block accepts X this cycle (combinational, independent of X_VALID)
//   S          explicit channel select, 00=A 01=B 10=C 11=D
//   AUTO       1 = route to the round-robin pointer, 0 = route by S
//   A,B,C,D    channel holding registers
//   V          channel valid flags, V[0]=A .. V[3]=D
//   ACK        per-channel consumer acknowledge
//   PTR        current round-robin pointer
//   STALL_CNT  saturating count of stalled input cycles (only when the
//              DEMUX_STALL_CNT_EN macro is defined)
//
// Optional feature macro: DEMUX_STALL_CNT_EN
// ============================================================================
module demux_1x4_nbit_reg #(
    parameter int n = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [n-1:0] X,
    input  logic         X_VALID,
    output logic         X_READY,
    input  logic [1:0]   S,
    input  logic         AUTO,
    output logic [n-1:0] A,
    output logic [n-1:0] B,
    output logic [n-1:0] C,
    output logic [n-1:0] D,
    output logic [3:0]   V,
    input  logic [3:0]   ACK,
    output logic [1:0]   PTR
`ifdef DEMUX_STALL_CNT_EN
    ,
    output logic [7:0]   STALL_CNT
`endif
);

    logic [n-1:0] chan_data [4];
    logic [3:0]   chan_valid;
    logic [1:0]   rr_ptr;
    logic [1:0]   target;
    logic         transfer;

    // The target channel and the ready signal are purely combinational so a
    // producer may change S or AUTO while stalled and see the new routing in
    // the same cycle. A full target can still accept when it is being acked
    // in the same cycle, giving one word per cycle per channel.
    always_comb begin
        target   = AUTO ? rr_ptr : S;
        X_READY  = RST_N & (~chan_valid[target] | ACK[target]);
        transfer = X_VALID & X_READY;
    end

    // Channel holding registers. Only the target channel loads on a transfer;
    // an ack only clears the valid flag and leaves stale data in place.
    // A transfer into an acked channel wins, so its valid flag stays set.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) begin
                chan_data[i]  <= '0;
                chan_valid[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (transfer && (target == 2'(i))) begin
                    chan_data[i]  <= X;
                    chan_valid[i] <= 1'b1;
                end else if (ACK[i]) begin
                    chan_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer advances only on transfers made in AUTO mode.
    // A stalled pointer channel blocks the input; no skipping is done.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rr_ptr <= 2'b00;
        end else if (transfer && AUTO) begin
            rr_ptr <= rr_ptr + 2'b01;
        end
    end

`ifdef DEMUX_STALL_CNT_EN
    logic [7:0] stall_cnt;

    // Counts cycles where the producer offered a word that was refused,
    // saturating at all ones; only reset clears it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_cnt <= 8'h00;
        end else if (X_VALID && !X_READY && (stall_cnt != 8'hFF)) begin
            stall_cnt <= stall_cnt + 8'h01;
        end
    end

    assign STALL_CNT = stall_cnt;
`endif

    assign A   = chan_data[0];
    assign B   = chan_data[1];
    assign C   = chan_data[2];
    assign D   = chan_data[3];
    assign V   = chan_valid;
    assign PTR = rr_ptr;

endmodule

// File: tb/tb_demux_1x4_nbit_reg.sv
// ============================================================================
// tb_demux_1x4_nbit_reg
// ----------------------------------------------------------------------------
// Self-checking bench for demux_1x4_nbit_reg (n = 8). Accepted words are
// pushed to a scoreboard queue when driven and popped after the accepting
// edge to compare against the channel register. A small behavioural model
// tracks valid flags, pointer and stall count.
// ============================================================================
module tb_demux_1x4_nbit_reg;

    logic       CLK;
    logic       RST_N;
    logic [7:0] X;
    logic       X_VALID;
    logic       X_READY;
    logic [1:0] S;
    logic       AUTO;
    logic [7:0] A, B, C, D;
    logic [3:0] V;
    logic [3:0] ACK;
    logic [1:0] PTR;
`ifdef DEMUX_STALL_CNT_EN
    logic [7:0] STALL_CNT;
`endif

    demux_1x4_nbit_reg #(.n(8)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .X       (X),
        .X_VALID (X_VALID),
        .X_READY (X_READY),
        .S       (S),
        .AUTO    (AUTO),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .V       (V),
        .ACK     (ACK),
        .PTR     (PTR)
`ifdef DEMUX_STALL_CNT_EN
        ,
        .STALL_CNT (STALL_CNT)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } sb_item_t;

    sb_item_t   sb_q [$];

    int         tests_run;
    int         fail_count;

    logic [7:0] m_data [4];
    logic [3:0] m_valid;
    logic [1:0] m_ptr;
    logic [7:0] m_stall;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] chanOut(input logic [1:0] ch);
        case (ch)
            2'd0:    return A;
            2'd1:    return B;
            2'd2:    return C;
            default: return D;
        endcase
    endfunction

    // Full visible state against the model.
    task automatic compareState(input string tag);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("%s.data%0d", tag, i), 32'(chanOut(2'(i))), 32'(m_data[i]));
        checkOutput({tag, ".V"}, 32'(V), 32'(m_valid));
        checkOutput({tag, ".PTR"}, 32'(PTR), 32'(m_ptr));
`ifdef DEMUX_STALL_CNT_EN
        checkOutput({tag, ".STALL"}, 32'(STALL_CNT), 32'(m_stall));
`endif
    endtask

    // One clock cycle of normal operation: drive at the falling edge, check
    // the combinational ready, update the model, then check after the edge.
    task automatic applyStimulus(input string tag, input logic [7:0] x, input logic valid,
                                 input logic [1:0] s, input logic auto_mode,
                                 input logic [3:0] ack);
        logic [1:0] t;
        logic       rdy;
        logic       xfer;
        sb_item_t   item;
        @(negedge CLK);
        RST_N   = 1'b1;
        X       = x;
        X_VALID = valid;
        S       = s;
        AUTO    = auto_mode;
        ACK     = ack;
        #1;
        t    = auto_mode ? m_ptr : s;
        rdy  = ~m_valid[t] | ack[t];
        xfer = valid & rdy;
        checkOutput({tag, ".X_READY"}, 32'(X_READY), 32'(rdy));
        if (xfer) begin
            item.ch   = t;
            item.data = x;
            sb_q.push_back(item);
        end
        for (int i = 0; i < 4; i++)
            if (ack[i]) m_valid[i] = 1'b0;
        if (xfer) begin
            m_valid[t] = 1'b1;
            m_data[t]  = x;
            if (auto_mode) m_ptr = m_ptr + 2'd1;
        end
        if (valid && !rdy && m_stall != 8'hFF) m_stall = m_stall + 8'd1;
        @(posedge CLK);
        #1;
        while (sb_q.size() > 0) begin
            item = sb_q.pop_front();
            checkOutput({tag, ".sb"}, 32'(chanOut(item.ch)), 32'(item.data));
        end
        compareState(tag);
    endtask

    // One reset cycle with arbitrary concurrent activity on the inputs.
    task automatic applyReset(input string tag, input logic [7:0] x, input logic valid,
                              input logic [3:0] ack);
        @(negedge CLK);
        RST_N   = 1'b0;
        X       = x;
        X_VALID = valid;
        S       = 2'b00;
        AUTO    = 1'b0;
        ACK     = ack;
        #1;
        checkOutput({tag, ".X_READY"}, 32'(X_READY), 32'd0);
        for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
        m_valid = 4'b0000;
        m_ptr   = 2'b00;
        m_stall = 8'h00;
        @(posedge CLK);
        #1;
        compareState(tag);
    endtask

    initial begin
        tests_run  = 0;
        fail_count = 0;
        RST_N      = 1'b0;
        X          = 8'h00;
        X_VALID    = 1'b0;
        S          = 2'b00;
        AUTO       = 1'b0;
        ACK        = 4'b0000;
        for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
        m_valid = 4'b0000;
        m_ptr   = 2'b00;
        m_stall = 8'h00;

        // Reset then explicit routing, one word per channel
        applyReset("rst0", 8'h00, 1'b0, 4'b0000);
        applyReset("rst1", 8'h00, 1'b0, 4'b0000);
        applyStimulus("sel_a", 8'hAA, 1'b1, 2'b00, 1'b0, 4'b0000);
        applyStimulus("sel_b", 8'h66, 1'b1, 2'b01, 1'b0, 4'b0000);
        applyStimulus("sel_c", 8'hDD, 1'b1, 2'b10, 1'b0, 4'b0000);
        applyStimulus("sel_d", 8'h11, 1'b1, 2'b11, 1'b0, 4'b0000);
        checkOutput("explicit.A", 32'(A), 32'h00AA);
        checkOutput("explicit.B", 32'(B), 32'h0066);
        checkOutput("explicit.C", 32'(C), 32'h00DD);
        checkOutput("explicit.D", 32'(D), 32'h0011);
        checkOutput("explicit.V", 32'(V), 32'hF);
        checkOutput("explicit.PTR", 32'(PTR), 32'h0);

        // Backpressure on A, then pass-through on the ack edge
        for (int k = 0; k < 3; k++) begin
            applyStimulus("bp_stall", 8'h55, 1'b1, 2'b00, 1'b0, 4'b0000);
            checkOutput("bp_hold.A", 32'(A), 32'h00AA);
        end
        applyStimulus("bp_ack", 8'h55, 1'b1, 2'b00, 1'b0, 4'b0001);
        checkOutput("bp_ack.A", 32'(A), 32'h0055);
        checkOutput("bp_ack.V0", 32'(V[0]), 32'h1);
`ifdef DEMUX_STALL_CNT_EN
        checkOutput("bp_ack.STALL", 32'(STALL_CNT), 32'd3);
`endif

        // Round-robin wrap with every channel always acked
        applyReset("rr_rst", 8'h00, 1'b0, 4'b0000);
        for (int k = 1; k <= 5; k++)
            applyStimulus("rr_wrap", 8'(k), 1'b1, 2'b11, 1'b1, 4'b1111);
        checkOutput("rr_wrap.A", 32'(A), 32'h05);
        checkOutput("rr_wrap.B", 32'(B), 32'h02);
        checkOutput("rr_wrap.C", 32'(C), 32'h03);
        checkOutput("rr_wrap.D", 32'(D), 32'h04);
        checkOutput("rr_wrap.PTR", 32'(PTR), 32'h1);

        // Round-robin stall: a full pointer channel blocks the input
        applyReset("rs_rst", 8'h00, 1'b0, 4'b0000);
        for (int k = 0; k < 4; k++)
            applyStimulus("rs_fill", 8'h10 + 8'(k), 1'b1, 2'b00, 1'b1, 4'b0000);
        applyStimulus("rs_block", 8'h14, 1'b1, 2'b00, 1'b1, 4'b0000);
        applyStimulus("rs_ack2", 8'h14, 1'b1, 2'b00, 1'b1, 4'b0100);
        checkOutput("rs_ack2.V", 32'(V), 32'hB);
        checkOutput("rs_ack2.PTR", 32'(PTR), 32'h0);
        checkOutput("rs_ack2.A", 32'(A), 32'h10);
        applyStimulus("rs_ack0", 8'h14, 1'b1, 2'b00, 1'b1, 4'b0001);
        applyStimulus("rs_ack1", 8'h15, 1'b1, 2'b00, 1'b1, 4'b0010);
        checkOutput("rs_pre.V", 32'(V), 32'hB);
        checkOutput("rs_pre.PTR", 32'(PTR), 32'h2);

        // Reset mid-stream with a word offered and all channels acked
        applyReset("mid_rst", 8'h77, 1'b1, 4'b1111);
        checkOutput("mid_rst.A", 32'(A), 32'h0);
        checkOutput("mid_rst.V", 32'(V), 32'h0);
        checkOutput("mid_rst.PTR", 32'(PTR), 32'h0);

        // Random traffic, including select changes while stalled
        for (int k = 0; k < 60; k++)
            applyStimulus("rand", 8'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                          4'($urandom_range(0, 15) & 4'($urandom)));

`ifdef DEMUX_STALL_CNT_EN
        // Stall counter saturation
        applyReset("sat_rst", 8'h00, 1'b0, 4'b0000);
        applyStimulus("sat_fill", 8'h42, 1'b1, 2'b00, 1'b0, 4'b0000);
        for (int k = 0; k < 260; k++)
            applyStimulus("sat", 8'h43, 1'b1, 2'b00, 1'b0, 4'b0000);
        checkOutput("sat.STALL", 32'(STALL_CNT), 32'hFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
